// File: rtl/cdc_fifo_src_arbiter.sv
// Packet-aware round-robin arbiter feeding the source port of a CDC gray FIFO.
// Grants are held for a whole packet; each beat is registered and tagged with its requester index.
module cdc_fifo_src_arbiter #(
  parameter int NumReq     = 4,
  parameter int DataWidth  = 32,
  parameter int StallLimit = 16,
  localparam int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq-1:0]           req_last_i,
  input  logic [NumReq*DataWidth-1:0] req_data_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        out_valid_o,
  output logic [DataWidth-1:0]        out_data_o,
  output logic                        out_last_o,
  output logic [IdxWidth-1:0]         out_idx_o,
  input  logic                        out_ready_i,
  output logic                        stall_err_o,
  input  logic                        clr_err_i
);

  localparam int CntWidth = $clog2(StallLimit + 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_e;

  state_e                state_q;
  logic [IdxWidth-1:0]   rr_ptr_q;
  logic [IdxWidth-1:0]   lock_idx_q;
  logic [CntWidth-1:0]   stall_cnt_q;
  logic [CntWidth-1:0]   stall_cnt_d;
  logic                  out_valid_q;
  logic [DataWidth-1:0]  out_data_q;
  logic                  out_last_q;
  logic [IdxWidth-1:0]   out_idx_q;
  logic                  stall_err_q;

  logic                  grant_vld;
  logic [IdxWidth-1:0]   grant_idx;
  logic [IdxWidth-1:0]   hi_idx;
  logic [IdxWidth-1:0]   lo_idx;
  logic                  hi_found;
  logic [NumReq-1:0]     grant;
  logic [DataWidth-1:0]  grant_data;
  logic                  grant_last;
  logic                  grant_valid_bit;
  logic [IdxWidth-1:0]   next_ptr;
  logic                  stage_en;
  logic                  accept;
  logic                  stall_set;

  assign stage_en = !out_valid_q || out_ready_i;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        lo_idx = IdxWidth'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IdxWidth'(i);
        end
      end
    end
    if (state_q == LOCK) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      grant_vld = |req_valid_i;
      grant_idx = hi_found ? hi_idx : lo_idx;
    end
  end

  always_comb begin
    grant           = '0;
    grant_data      = '0;
    grant_last      = 1'b0;
    grant_valid_bit = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_idx == IdxWidth'(i)) begin
        grant[i]        = grant_vld;
        grant_data      = req_data_i[i*DataWidth +: DataWidth];
        grant_last      = req_last_i[i];
        grant_valid_bit = req_valid_i[i];
      end
    end
  end

  assign req_ready_o = rst_i ? '0 : (grant & {NumReq{stage_en}});
  assign accept      = |(req_valid_i & req_ready_o);
  assign next_ptr    = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + IdxWidth'(1);

  // Watchdog only counts missing valid from the locked requester, never FIFO backpressure.
  always_comb begin
    stall_cnt_d = '0;
    if (state_q == LOCK && !grant_valid_bit) begin
      if (stall_cnt_q == CntWidth'(StallLimit)) begin
        stall_cnt_d = stall_cnt_q;
      end else begin
        stall_cnt_d = stall_cnt_q + CntWidth'(1);
      end
    end
  end

  assign stall_set = (stall_cnt_d == CntWidth'(StallLimit));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      stall_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      stall_err_q <= 1'b0;
    end else begin
      if (stage_en) begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= grant_data;
          out_last_q <= grant_last;
          out_idx_q  <= grant_idx;
        end
      end
      stall_cnt_q <= stall_cnt_d;
      if (stall_set) begin
        stall_err_q <= 1'b1;
      end else if (clr_err_i) begin
        stall_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (grant_last) begin
              rr_ptr_q <= next_ptr;
            end else begin
              lock_idx_q <= grant_idx;
              state_q    <= LOCK;
            end
          end
        end
        LOCK: begin
          if (accept && grant_last) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_idx_o   = out_idx_q;
  assign stall_err_o = stall_err_q;

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed bench for cdc_fifo_src_arbiter; emitted beats are checked against a queue of expected beats.
module tb_cdc_fifo_src_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   reqValid;
  logic [3:0]   reqLast;
  logic [127:0] reqData;
  logic [3:0]   reqReady;
  logic         outValid;
  logic [31:0]  outData;
  logic         outLast;
  logic [1:0]   outIdx;
  logic         outReady;
  logic         stallErr;
  logic         clrErr;

  int checks   = 0;
  int failures = 0;
  logic [34:0] expQ[$];

  cdc_fifo_src_arbiter #(
    .NumReq(4),
    .DataWidth(32),
    .StallLimit(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(reqValid),
    .req_last_i(reqLast),
    .req_data_i(reqData),
    .req_ready_o(reqReady),
    .out_valid_o(outValid),
    .out_data_o(outData),
    .out_last_o(outLast),
    .out_idx_o(outIdx),
    .out_ready_i(outReady),
    .stall_err_o(stallErr),
    .clr_err_i(clrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [34:0] beat(input logic [1:0] idx, input logic last, input logic [31:0] data);
    return {idx, last, data};
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every handshake on the output side must match the oldest expected beat.
  task automatic checkOutput();
    logic [34:0] exp;
    if (outValid && outReady) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL beat_unexpected observed=%0h expected=none", {outIdx, outLast, outData});
      end else begin
        exp = expQ.pop_front();
        checkEq("beat", 64'({outIdx, outLast, outData}), 64'(exp));
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setData(input int i, input logic [31:0] d);
    reqData[i*32 +: 32] = d;
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = 4'b1111;
    reqLast  = 4'b1111;
    reqData  = '0;
    outReady = 1'b1;
    clrErr   = 1'b0;
    for (int i = 0; i < 4; i++) setData(i, 32'hA000_0000 + 32'(i));

    // Reset holds everything quiet even with all requesters valid
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_ready", 64'(reqReady), 64'(4'b0000));
    checkEq("rst_valid", 64'(outValid), 64'(1'b0));
    checkEq("rst_idx", 64'(outIdx), 64'(2'd0));
    checkEq("rst_err", 64'(stallErr), 64'(1'b0));
    rst = 1'b0;
    #1;

    // Single-beat packets from everyone rotate 0,1,2,3,0,1
    checkEq("rr_first_ready", 64'(reqReady), 64'(4'b0001));
    expQ.push_back(beat(2'd0, 1'b1, 32'hA000_0000));
    expQ.push_back(beat(2'd1, 1'b1, 32'hA000_0001));
    expQ.push_back(beat(2'd2, 1'b1, 32'hA000_0002));
    expQ.push_back(beat(2'd3, 1'b1, 32'hA000_0003));
    expQ.push_back(beat(2'd0, 1'b1, 32'hA000_0000));
    expQ.push_back(beat(2'd1, 1'b1, 32'hA000_0001));
    applyStimulus(6);
    reqValid = 4'b0000;
    applyStimulus(1);

    // req0 three-beat packet while req1 waits; rr_ptr is 2 so req0 wins by wrap
    reqValid = 4'b0011;
    reqLast  = 4'b0010;
    setData(0, 32'hB000_0000);
    #1;
    checkEq("pkt_first_ready", 64'(reqReady), 64'(4'b0001));
    expQ.push_back(beat(2'd0, 1'b0, 32'hB000_0000));
    expQ.push_back(beat(2'd0, 1'b0, 32'hB000_0001));
    expQ.push_back(beat(2'd0, 1'b1, 32'hB000_0002));
    expQ.push_back(beat(2'd1, 1'b1, 32'hA000_0001));
    applyStimulus(1);
    setData(0, 32'hB000_0001);
    #1;
    checkEq("lock_ready_beat1", 64'(reqReady), 64'(4'b0001));
    applyStimulus(1);
    setData(0, 32'hB000_0002);
    reqLast = 4'b0011;
    #1;
    checkEq("lock_ready_beat2", 64'(reqReady), 64'(4'b0001));
    applyStimulus(1);
    reqValid = 4'b0010;
    #1;
    checkEq("after_pkt_ready", 64'(reqReady), 64'(4'b0010));
    applyStimulus(1);
    reqValid = 4'b0000;
    applyStimulus(1);

    // FIFO backpressure: output held, no ready, nothing lost or duplicated
    reqValid = 4'b0100;
    reqLast  = 4'b1111;
    setData(2, 32'hC000_0000);
    expQ.push_back(beat(2'd2, 1'b1, 32'hC000_0000));
    expQ.push_back(beat(2'd2, 1'b1, 32'hC000_0001));
    expQ.push_back(beat(2'd2, 1'b1, 32'hC000_0002));
    applyStimulus(1);
    outReady = 1'b0;
    setData(2, 32'hC000_0001);
    #1;
    for (int k = 0; k < 5; k++) begin
      checkEq("bp_ready", 64'(reqReady), 64'(4'b0000));
      checkEq("bp_data_stable", 64'(outData), 64'(32'hC000_0000));
      applyStimulus(1);
    end
    outReady = 1'b1;
    #1;
    checkEq("bp_resume_ready", 64'(reqReady), 64'(4'b0100));
    applyStimulus(1);
    setData(2, 32'hC000_0002);
    applyStimulus(1);
    reqValid = 4'b0000;
    applyStimulus(1);

    // Lock on req2 then starve it: error after the 16th idle cycle, sticky until cleared
    reqValid = 4'b0100;
    reqLast  = 4'b0000;
    setData(2, 32'hD000_0000);
    expQ.push_back(beat(2'd2, 1'b0, 32'hD000_0000));
    expQ.push_back(beat(2'd2, 1'b1, 32'hD000_0001));
    applyStimulus(1);
    reqValid = 4'b0001;
    applyStimulus(15);
    checkEq("stall_15_err", 64'(stallErr), 64'(1'b0));
    checkEq("stall_lock_ready", 64'(reqReady), 64'(4'b0100));
    applyStimulus(1);
    checkEq("stall_16_err", 64'(stallErr), 64'(1'b1));
    applyStimulus(2);
    checkEq("stall_sticky", 64'(stallErr), 64'(1'b1));
    clrErr = 1'b1;
    applyStimulus(1);
    checkEq("stall_set_wins", 64'(stallErr), 64'(1'b1));
    reqValid = 4'b0100;
    reqLast  = 4'b0100;
    setData(2, 32'hD000_0001);
    applyStimulus(1);
    clrErr   = 1'b0;
    reqValid = 4'b0000;
    checkEq("stall_cleared", 64'(stallErr), 64'(1'b0));
    applyStimulus(1);

    // Long FIFO backpressure during a lock must not trip the watchdog
    reqValid = 4'b1000;
    reqLast  = 4'b0000;
    setData(3, 32'hE000_0000);
    expQ.push_back(beat(2'd3, 1'b0, 32'hE000_0000));
    expQ.push_back(beat(2'd3, 1'b1, 32'hE000_0001));
    applyStimulus(1);
    outReady = 1'b0;
    setData(3, 32'hE000_0001);
    applyStimulus(20);
    checkEq("bp_no_stall_err", 64'(stallErr), 64'(1'b0));
    checkEq("bp_lock_data", 64'(outData), 64'(32'hE000_0000));
    outReady = 1'b1;
    reqLast  = 4'b1000;
    applyStimulus(1);
    reqValid = 4'b0000;
    applyStimulus(1);

    // Reset in the middle of a req3 packet: arbitration restarts at index 0
    reqValid = 4'b1000;
    reqLast  = 4'b0000;
    setData(3, 32'hF000_0000);
    expQ.push_back(beat(2'd3, 1'b0, 32'hF000_0000));
    applyStimulus(1);
    reqValid = 4'b1010;
    reqLast  = 4'b0010;
    setData(3, 32'hF000_0001);
    applyStimulus(1);
    rst = 1'b1;
    #2;
    checkEq("midrst_valid", 64'(outValid), 64'(1'b0));
    checkEq("midrst_ready", 64'(reqReady), 64'(4'b0000));
    rst = 1'b0;
    #1;
    checkEq("postrst_ready", 64'(reqReady), 64'(4'b0010));
    expQ.push_back(beat(2'd1, 1'b1, 32'hA000_0001));
    applyStimulus(1);
    reqValid = 4'b0000;
    applyStimulus(2);
    checkEq("queue_drained", 64'(expQ.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
